// File: rtl/intr_pkg.sv
// Shared types, default I/O port IDs and priority helper
// for the RAT MCU interrupt controller.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    localparam logic [7:0] MASK_PORT_DEF = 8'h30;
    localparam logic [7:0] CLR_PORT_DEF  = 8'h31;
    localparam logic [7:0] STAT_PORT_DEF = 8'h32;
    localparam logic [7:0] ID_PORT_DEF   = 8'h33;

    // Index 0 wins; an all-zero vector yields 0.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin followed by
// a rising-edge detector against the previous synchronised value.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: edge-latched pending bits,
// software mask, single request/ack handshake and in-service tracking.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
    parameter logic [7:0] CLR_PORT  = CLR_PORT_DEF,
    parameter logic [7:0] STAT_PORT = STAT_PORT_DEF,
    parameter logic [7:0] ID_PORT   = ID_PORT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             io_strb,
    output logic [7:0]       in_data,
    output logic             int_req,
    input  logic             int_ack,
    input  logic             int_done,
    output logic [2:0]       active_id
);

    intr_state_t      state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [2:0]       active_q, active_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_mask;
    logic [N_SRC-1:0] ack_clear;
    logic [7:0]       elig8;
    logic [7:0]       pend8;
    logic [7:0]       sel_oh;
    logic [2:0]       sel;
    logic             in_service;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge u_sync_edge (
            .clk   (clk),
            .reset (reset),
            .d     (irq_src[i]),
            .rise  (rise[i])
        );
    end

    assign eligible = pending_q & mask_q;

    always_comb begin
        elig8              = '0;
        elig8[N_SRC-1:0]   = eligible;
        pend8              = '0;
        pend8[N_SRC-1:0]   = pending_q;
    end

    assign sel    = lowest_set(elig8);
    assign sel_oh = 8'(1) << sel;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        mask_d    = mask_q;
        clr_mask  = '0;
        ack_clear = '0;

        if (io_strb) begin
            if (port_id == MASK_PORT) begin
                mask_d = out_port[N_SRC-1:0];
            end else if (port_id == CLR_PORT) begin
                clr_mask = out_port[N_SRC-1:0];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack racing a mask/clear still enters service,
                // keeping the previous ID since nothing is left to pick.
                if (int_ack) begin
                    state_d = SERVICE;
                    if (|eligible) begin
                        active_d  = sel;
                        ack_clear = sel_oh[N_SRC-1:0];
                    end
                end else if (!(|eligible)) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q & ~clr_mask & ~ack_clear) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            active_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            active_q  <= active_d;
        end
    end

    assign int_req    = (state_q == REQ);
    assign in_service = (state_q == SERVICE);
    assign active_id  = active_q;

    always_comb begin
        in_data = 8'h00;
        if (port_id == STAT_PORT) begin
            in_data = pend8;
        end else if (port_id == ID_PORT) begin
            in_data = {in_service, 4'b0000, active_q};
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: masking, priority, ack/done handshake,
// clear-while-requesting, back-to-back service and mid-service reset.
module tb_intr_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] irq_src;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_data;
    logic       int_req;
    logic       int_ack;
    logic       int_done;
    logic [2:0] active_id;

    int checks = 0;
    int errors = 0;

    intr_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .port_id   (port_id),
        .out_port  (out_port),
        .io_strb   (io_strb),
        .in_data   (in_data),
        .int_req   (int_req),
        .int_ack   (int_ack),
        .int_done  (int_done),
        .active_id (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id  = p;
        out_port = d;
        io_strb  = 1'b1;
        tick();
        io_strb  = 1'b0;
        port_id  = 8'h00;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] d);
        port_id = p;
        #1;
        d = in_data;
        port_id = 8'h00;
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 4 && !int_req; n++) begin
            tick();
        end
        chk(tag, {7'b0, int_req}, 8'h01);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    logic [7:0] r;

    initial begin
        reset    = 1'b1;
        irq_src  = 8'h00;
        port_id  = 8'h00;
        out_port = 8'h00;
        io_strb  = 1'b0;
        int_ack  = 1'b0;
        int_done = 1'b0;
        tick(2);
        reset = 1'b0;
        tick();

        chk("rst_req", {7'b0, int_req}, 8'h00);
        chk("rst_aid", {5'b0, active_id}, 8'h00);
        rd(8'h32, r); chk("rst_stat", r, 8'h00);
        rd(8'h33, r); chk("rst_id", r, 8'h00);
        rd(8'h55, r); chk("other_port", r, 8'h00);

        // masked source latches but never requests
        wr(8'h30, 8'h00);
        irq_src = 8'h04;
        tick(3);
        rd(8'h32, r); chk("masked_pend", r, 8'h04);
        tick(4);
        chk("masked_noreq", {7'b0, int_req}, 8'h00);
        irq_src = 8'h00;
        wr(8'h31, 8'hFF);
        rd(8'h32, r); chk("clr_all", r, 8'h00);

        // single source, full handshake
        wr(8'h30, 8'hFF);
        tick(3);
        irq_src = 8'h04;
        wait_req("lat_src2");
        ack();
        chk("aid_2", {5'b0, active_id}, 8'h02);
        rd(8'h32, r); chk("ack_clr2", r, 8'h00);
        rd(8'h33, r); chk("id_svc2", r, 8'h82);
        chk("svc_noreq", {7'b0, int_req}, 8'h00);
        done();
        rd(8'h33, r); chk("id_done2", r, 8'h02);
        irq_src = 8'h00;
        tick(3);

        // priority: sources 5 and 1 together
        irq_src = 8'h22;
        wait_req("lat_pair");
        rd(8'h32, r); chk("pair_pend", r, 8'h22);
        ack();
        chk("aid_1", {5'b0, active_id}, 8'h01);
        rd(8'h32, r); chk("pair_left", r, 8'h20);
        done();
        chk("b2b_idle", {7'b0, int_req}, 8'h00);
        tick();
        chk("b2b_req", {7'b0, int_req}, 8'h01);
        ack();
        chk("aid_5", {5'b0, active_id}, 8'h05);
        rd(8'h32, r); chk("pair_empty", r, 8'h00);
        done();
        irq_src = 8'h00;
        tick(3);

        // clear while requesting withdraws the request
        irq_src = 8'h01;
        wait_req("lat_src0");
        wr(8'h31, 8'hFF);
        rd(8'h32, r); chk("req_clr_pend", r, 8'h00);
        chk("req_clr_hold", {7'b0, int_req}, 8'h01);
        tick();
        chk("req_clr_drop", {7'b0, int_req}, 8'h00);
        rd(8'h33, r); chk("req_clr_id", r, 8'h05);
        irq_src = 8'h00;
        tick(3);

        // edge during service waits for done
        irq_src = 8'h40;
        wait_req("lat_src6");
        ack();
        chk("aid_6", {5'b0, active_id}, 8'h06);
        irq_src = 8'h48;
        tick(4);
        rd(8'h32, r); chk("svc_pend3", r, 8'h08);
        chk("svc_hold", {7'b0, int_req}, 8'h00);
        done();
        chk("svc_gap", {7'b0, int_req}, 8'h00);
        tick();
        chk("svc_next_req", {7'b0, int_req}, 8'h01);
        ack();
        chk("aid_3", {5'b0, active_id}, 8'h03);

        // reset mid-service with source 4 pending
        irq_src = 8'h58;
        tick(3);
        rd(8'h32, r); chk("pre_rst_pend", r, 8'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_req", {7'b0, int_req}, 8'h00);
        rd(8'h32, r); chk("mrst_stat", r, 8'h00);
        rd(8'h33, r); chk("mrst_id", r, 8'h00);
        // held pins re-edge after reset; mask is back to 0
        tick(4);
        rd(8'h32, r); chk("mrst_relatch", r, 8'h58);
        chk("mrst_masked", {7'b0, int_req}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
